transform_sequencer: RTL

Sequences the unified FFT/NTT transformation unit over one or more RNS limbs. It accepts a transform command, loads per-limb constants from a host-writable table and drives the unit's configuration. It holds the unit's run-control reset, waits for completion, and hands the polynomial BRAM banks back to the host between jobs. It sits between the host/command front end and the unified transformation instance plus its BRAM muxes.

---
 rtl/transform_pkg.sv | 26 ++
 rtl/transform_const_table.sv | 34 +++
 rtl/transform_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/transform_pkg.sv
// Shared types for the FFT/NTT transform sequencer: FSM states, unit
// configuration bundle and default widths.
package transform_pkg;

  localparam int DEF_M        = 17;
  localparam int DEF_K_BITS   = 4;
  localparam int DEF_SEL_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic                    is_fft;
    logic                    is_dif;
    logic [DEF_K_BITS-1:0]   k;
    logic [DEF_M-1:0]        qm;
    logic [DEF_SEL_BITS-1:0] sel;
  } xf_cfg_t;

endpackage

// File: rtl/transform_const_table.sv
// Per-limb constant register file: synchronous write, enabled registered read.
// A same-cycle write and read of one address returns the previous contents.
module transform_const_table
  import transform_pkg::*;
#(
  parameter int W = DEF_M + DEF_SEL_BITS,
  parameter int A = DEF_K_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem_q [2**A];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Only the read register is reset; the table contents persist.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/transform_sequencer.sv
// Sequences the unified FFT/NTT unit over RNS limbs: loads per-limb constants,
// holds/releases the unit's run reset and returns BRAM ownership to the host.
module transform_sequencer
  import transform_pkg::*;
#(
  parameter int M            = DEF_M,
  parameter int K_BITS       = DEF_K_BITS,
  parameter int SEL_BITS     = DEF_SEL_BITS,
  parameter int SETUP_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 1 << 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_fft,
  input  logic                cmd_forward,
  input  logic [K_BITS-1:0]   cmd_k_start,
  input  logic [K_BITS-1:0]   cmd_num_limbs,
  input  logic                cfg_we,
  input  logic [K_BITS-1:0]   cfg_addr,
  input  logic [M-1:0]        cfg_qm,
  input  logic [SEL_BITS-1:0] cfg_sel,
  output logic                xf_rst,
  output logic                xf_is_fft,
  output logic                xf_is_dif,
  output logic [K_BITS-1:0]   xf_current_k,
  output logic [M-1:0]        xf_qm,
  output logic [SEL_BITS-1:0] xf_constants_sel,
  input  logic                xf_done,
  output logic                bram_host,
  output logic                busy,
  output logic                limb_done,
  output logic                job_done,
  output logic                err_timeout,
  output state_e              dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [K_BITS-1:0]      remaining_q, remaining_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic                   is_fft_q, is_fft_d;
  logic                   is_dif_q, is_dif_d;
  logic                   armed_q, armed_d;
  logic                   limb_done_q, limb_done_d;
  logic                   load_cfg;
  logic [M+SEL_BITS-1:0]  tbl_rdata;
  xf_cfg_t                cfg;

  // The table read register doubles as the qm/sel config register, so it is
  // loaded on the same edge as k/is_fft/is_dif (the SETUP entry edge).
  transform_const_table #(
    .W (M + SEL_BITS),
    .A (K_BITS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata ({cfg_qm, cfg_sel}),
    .re    (load_cfg),
    .raddr (k_d),
    .rdata (tbl_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    k_d         = k_q;
    is_fft_d    = is_fft_q;
    is_dif_d    = is_dif_q;
    armed_d     = 1'b0;
    limb_done_d = 1'b0;
    load_cfg    = 1'b0;
    case (state_q)
      // Command handshake: a transfer happens on any cycle where cmd_valid
      // and cmd_ready are both high; cmd_ready is high exactly in IDLE.
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d     = ST_SETUP;
          cnt_d       = '0;
          k_d         = cmd_k_start;
          is_fft_d    = cmd_is_fft;
          is_dif_d    = cmd_is_fft ? cmd_forward : ~cmd_forward;
          remaining_d = (cmd_is_fft || cmd_num_limbs == '0) ? K_BITS'(1) : cmd_num_limbs;
          load_cfg    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // done is accepted only after it has been seen low in this RUN.
        armed_d = armed_q | ~xf_done;
        if (xf_done && armed_q) begin
          state_d     = ST_DRAIN;
          cnt_d       = '0;
          limb_done_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d       = '0;
          remaining_d = remaining_q - K_BITS'(1);
          if (remaining_q > K_BITS'(1)) begin
            state_d  = ST_SETUP;
            k_d      = k_q + K_BITS'(1);
            load_cfg = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      k_q         <= '0;
      is_fft_q    <= 1'b0;
      is_dif_q    <= 1'b0;
      armed_q     <= 1'b0;
      limb_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      k_q         <= k_d;
      is_fft_q    <= is_fft_d;
      is_dif_q    <= is_dif_d;
      armed_q     <= armed_d;
      limb_done_q <= limb_done_d;
    end
  end

  always_comb begin
    cfg.is_fft = is_fft_q;
    cfg.is_dif = is_dif_q;
    cfg.k      = k_q;
    cfg.qm     = tbl_rdata[M+SEL_BITS-1:SEL_BITS];
    cfg.sel    = tbl_rdata[SEL_BITS-1:0];
  end

  assign xf_is_fft        = cfg.is_fft;
  assign xf_is_dif        = cfg.is_dif;
  assign xf_current_k     = cfg.k;
  assign xf_qm            = cfg.qm;
  assign xf_constants_sel = cfg.sel;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign xf_rst      = (state_q != ST_RUN);
  assign bram_host   = (state_q == ST_IDLE) || (state_q == ST_FINISH) || (state_q == ST_ABORT);
  assign busy        = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign limb_done   = limb_done_q;
  assign job_done    = (state_q == ST_FINISH);
  assign err_timeout = (state_q == ST_ABORT);
  assign dbg_state   = state_q;

endmodule
